// File: rtl/mb_crc3_tx_ctrl.sv
// rtl/mb_crc3_tx_ctrl.sv - Frame sequencer that feeds a serial CRC-3 (x^3+x+1) generator
module mb_crc3_tx_ctrl #(
    parameter int DATA_W = 8,
    parameter int GAP    = 1
) (
    input  logic              GCLK,
    input  logic              CLEAR_bar,
    input  logic [DATA_W-1:0] Data_In,
    input  logic              Load,
    output logic              Ready,
    output logic              Gen_Serial_In,
    output logic              Select,
    output logic              Gen_Clear_bar,
    output logic              Frame_Sync,
    output logic              Done,
    output logic              Busy
);
    // Counter must hold the largest reload value: DATA_W-1, GAP-1 or 2.
    localparam int MAX_DG  = (DATA_W > GAP) ? DATA_W : GAP;
    localparam int MAX_ALL = (MAX_DG > 3) ? MAX_DG : 3;
    localparam int CNT_W   = $clog2(MAX_ALL);

    localparam logic [CNT_W-1:0] DATA_LOAD = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CRC_LOAD  = CNT_W'(2);
    localparam logic [CNT_W-1:0] GAP_LOAD  = (GAP > 0) ? CNT_W'(GAP - 1) : '0;
    localparam bit               HAS_GAP   = (GAP > 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_CRC  = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              frame_sync_d;

    // Next-state, counter and shift-register logic; outputs are derived from
    // the next state so they can be registered and still line up with it.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shreg_d      = shreg_q;
        frame_sync_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (Load) begin
                    state_d      = S_DATA;
                    cnt_d        = DATA_LOAD;
                    shreg_d      = Data_In;
                    frame_sync_d = 1'b1;
                end
            end
            S_DATA: begin
                shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
                if (cnt_q == '0) begin
                    state_d = S_CRC;
                    cnt_d   = CRC_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_CRC: begin
                if (cnt_q == '0) begin
                    if (HAS_GAP) begin
                        state_d = S_GAP;
                        cnt_d   = GAP_LOAD;
                    end else begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_GAP: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and registered outputs; generator clear is glitch-free because it is a flop.
    always_ff @(posedge GCLK) begin
        if (!CLEAR_bar) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            shreg_q       <= '0;
            Ready         <= 1'b1;
            Select        <= 1'b0;
            Gen_Serial_In <= 1'b0;
            Gen_Clear_bar <= 1'b0;
            Frame_Sync    <= 1'b0;
            Done          <= 1'b0;
            Busy          <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            shreg_q       <= shreg_d;
            Ready         <= (state_d == S_IDLE);
            Select        <= (state_d == S_DATA);
            Gen_Serial_In <= (state_d == S_DATA) && shreg_d[DATA_W-1];
            Gen_Clear_bar <= (state_d == S_DATA) || (state_d == S_CRC);
            Frame_Sync    <= frame_sync_d;
            Done          <= (state_d == S_CRC) && (cnt_d == '0);
            Busy          <= (state_d != S_IDLE);
        end
    end
endmodule

// File: tb/tb_mb_crc3_tx_ctrl.sv
// tb/tb_mb_crc3_tx_ctrl.sv - Self-checking bench for mb_crc3_tx_ctrl
module tb_mb_crc3_tx_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       clear8 = 1'b0, load8 = 1'b1;
    logic [7:0] data8 = 8'h80;
    logic       ready8, sin8, sel8, gclr8, fs8, done8, busy8;
    logic       clear4 = 1'b0, load4 = 1'b0;
    logic [3:0] data4 = 4'h0;
    logic       ready4, sin4, sel4, gclr4, fs4, done4, busy4;

    mb_crc3_tx_ctrl #(.DATA_W(8), .GAP(1)) dut8 (
        .GCLK(clk), .CLEAR_bar(clear8), .Data_In(data8), .Load(load8),
        .Ready(ready8), .Gen_Serial_In(sin8), .Select(sel8),
        .Gen_Clear_bar(gclr8), .Frame_Sync(fs8), .Done(done8), .Busy(busy8)
    );

    mb_crc3_tx_ctrl #(.DATA_W(4), .GAP(0)) dut4 (
        .GCLK(clk), .CLEAR_bar(clear4), .Data_In(data4), .Load(load4),
        .Ready(ready4), .Gen_Serial_In(sin4), .Select(sel4),
        .Gen_Clear_bar(gclr4), .Frame_Sync(fs4), .Done(done4), .Busy(busy4)
    );

    // Serial CRC-3 generator attached to each controller; link = generator output.
    function automatic logic [2:0] gen_next(input logic [2:0] r, input logic clr_n,
                                            input logic sel, input logic din);
        logic fb;
        if (clr_n !== 1'b1) return 3'b000;
        if (sel) begin
            fb = din ^ r[2];
            return {r[1], r[0] ^ fb, fb};
        end
        return {r[1:0], 1'b0};
    endfunction

    logic [2:0] gen8_r, gen4_r;
    logic       link8, link4;
    always @(posedge clk) gen8_r <= gen_next(gen8_r, gclr8, sel8, sin8);
    always @(posedge clk) gen4_r <= gen_next(gen4_r, gclr4, sel4, sin4);
    assign link8 = sel8 ? sin8 : gen8_r[2];
    assign link4 = sel4 ? sin4 : gen4_r[2];

    // Remainder of data(x)*x^3 divided by x^3+x+1, by polynomial long division.
    function automatic logic [2:0] crc3_ref(input logic [31:0] word, input int dw);
        logic [34:0] m;
        logic [34:0] poly;
        m    = 35'(word) << 3;
        poly = 35'b1011;
        for (int i = dw + 2; i >= 3; i--)
            if (m[i]) m = m ^ (poly << (i - 3));
        return m[2:0];
    endfunction

    // Timeline model: k = cycles since accept edge (0 = idle). Returns
    // {ready, select, serial_in, clear_bar, frame_sync, done, busy}.
    function automatic logic [6:0] model_out(input int dw, input int gp, input int k,
                                             input logic [31:0] w);
        logic in_data, in_frame, busy;
        in_data  = (k >= 1) && (k <= dw);
        in_frame = (k >= 1) && (k <= dw + 3);
        busy     = (k >= 1) && (k <= dw + 3 + gp);
        return {!busy, in_data, in_data ? w[dw-k] : 1'b0, in_frame,
                k == 1, k == dw + 3, busy};
    endfunction

    function automatic int next_k(input int dw, input int gp, input int k,
                                  input logic clr_n, input logic ld);
        if (!clr_n) return 0;
        if (k == 0) return ld ? 1 : 0;
        if (k >= dw + 3 + gp) return 0;
        return k + 1;
    endfunction

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       clear;
        logic       load;
        logic [7:0] data;
        logic [7:0] exp;   // {link, ready, select, serial_in, clear_bar, frame_sync, done, busy}
    } vec_t;
    vec_t tbl[16];

    int         t, fs2_at, clr_low, done_cnt, done_at, ready_at, k8, k4;
    logic [2:0] crc_a, crc_b;
    logic [31:0] w8, w4;

    initial begin
        // Reset with Load high, then one 8'h80 frame; Load pulses in DATA, CRC, GAP.
        tbl[0]  = '{1'b0, 1'b1, 8'h80, 8'b0100_0000};
        tbl[1]  = '{1'b0, 1'b1, 8'h80, 8'b0100_0000};
        tbl[2]  = '{1'b1, 1'b1, 8'h80, 8'b1011_1101};
        tbl[3]  = '{1'b1, 1'b0, 8'h00, 8'b0010_1001};
        tbl[4]  = '{1'b1, 1'b0, 8'h00, 8'b0010_1001};
        tbl[5]  = '{1'b1, 1'b1, 8'hFF, 8'b0010_1001};
        tbl[6]  = '{1'b1, 1'b0, 8'h00, 8'b0010_1001};
        tbl[7]  = '{1'b1, 1'b0, 8'h00, 8'b0010_1001};
        tbl[8]  = '{1'b1, 1'b0, 8'h00, 8'b0010_1001};
        tbl[9]  = '{1'b1, 1'b0, 8'h00, 8'b0010_1001};
        tbl[10] = '{1'b1, 1'b0, 8'h00, 8'b0000_1001};
        tbl[11] = '{1'b1, 1'b1, 8'hFF, 8'b1000_1001};
        tbl[12] = '{1'b1, 1'b0, 8'h00, 8'b1000_1011};
        tbl[13] = '{1'b1, 1'b0, 8'h00, 8'b0000_0001};
        tbl[14] = '{1'b1, 1'b1, 8'hFF, 8'b0100_0000};
        tbl[15] = '{1'b1, 1'b0, 8'h00, 8'b0100_0000};

        for (int i = 0; i < 16; i++) begin
            clear8 = tbl[i].clear;
            load8  = tbl[i].load;
            data8  = tbl[i].data;
            tick();
            check($sformatf("vec%0d", i),
                  {link8, ready8, sel8, sin8, gclr8, fs8, done8, busy8}, tbl[i].exp);
        end

        // Back-to-back frames with Load held high.
        load8 = 1'b1; data8 = 8'hA5;
        tick();
        check("b2b_fs1", fs8, 1'b1);
        data8 = 8'h3C;
        t = 1; fs2_at = -1; clr_low = 0; crc_a = 3'b0; crc_b = 3'b0; done_cnt = 0;
        while (t < 40) begin
            tick();
            t++;
            if (fs8 && fs2_at < 0) begin
                fs2_at = t;
                load8  = 1'b0;
            end
            if (fs2_at < 0 && !gclr8) clr_low++;
            if (done8) done_cnt++;
            if (!sel8 && gclr8) begin
                if (fs2_at < 0) crc_a = {crc_a[1:0], link8};
                else            crc_b = {crc_b[1:0], link8};
            end
        end
        check("b2b_period", 32'(fs2_at - 1), 32'd13);
        check("b2b_clear_low", 32'(clr_low), 32'd2);
        check("b2b_crc_a", crc_a, crc3_ref(32'hA5, 8));
        check("b2b_crc_b", crc_b, crc3_ref(32'h3C, 8));
        check("b2b_done_cnt", 32'(done_cnt), 32'd2);

        // Reset in cycle 5 of the DATA phase.
        load8 = 1'b1; data8 = 8'hFF;
        tick();
        load8 = 1'b0;
        for (int i = 2; i <= 5; i++) tick();
        clear8 = 1'b0;
        tick();
        clear8 = 1'b1;
        check("mid_reset_outs", {ready8, sel8, gclr8, done8, busy8}, 5'b10000);
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done8) done_cnt++;
        end
        check("mid_reset_no_done", 32'(done_cnt), 32'd0);
        load8 = 1'b1; data8 = 8'h80;
        tick();
        load8 = 1'b0;
        crc_a = 3'b0; done_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (done8) done_cnt++;
            if (!sel8 && gclr8) crc_a = {crc_a[1:0], link8};
        end
        check("post_reset_crc", crc_a, 3'b011);
        check("post_reset_done", 32'(done_cnt), 32'd1);

        // GAP=0, DATA_W=4 build.
        clear4 = 1'b1;
        tick();
        load4 = 1'b1; data4 = 4'h1;
        tick();
        load4 = 1'b0; data4 = 4'h0;
        done_at = -1; ready_at = -1; crc_a = 3'b0;
        for (int c = 2; c <= 8; c++) begin
            tick();
            if (done4 && done_at < 0) done_at = c;
            if (ready4 && ready_at < 0) ready_at = c;
            if (!sel4 && gclr4) crc_a = {crc_a[1:0], link4};
        end
        check("gap0_done_cycle", 32'(done_at), 32'd7);
        check("gap0_ready_cycle", 32'(ready_at), 32'd8);
        check("gap0_crc", crc_a, crc3_ref(32'h1, 4));
        load4 = 1'b1; data4 = 4'h9;
        tick();
        load4 = 1'b0;
        check("gap0_reaccept", {fs4, busy4, sin4}, 3'b111);

        // Randomized stimulus on both builds against the timeline model.
        clear8 = 1'b0; clear4 = 1'b0; load8 = 1'b0; load4 = 1'b0;
        tick();
        k8 = 0; k4 = 0; w8 = '0; w4 = '0;
        for (int c = 0; c < 1500; c++) begin
            clear8 = ($urandom_range(0, 63) != 0);
            load8  = ($urandom_range(0, 2) == 0);
            data8  = 8'($urandom);
            clear4 = ($urandom_range(0, 63) != 0);
            load4  = ($urandom_range(0, 2) == 0);
            data4  = 4'($urandom);
            if (clear8 && k8 == 0 && load8) w8 = 32'(data8);
            if (clear4 && k4 == 0 && load4) w4 = 32'(data4);
            k8 = next_k(8, 1, k8, clear8, load8);
            k4 = next_k(4, 0, k4, clear4, load4);
            tick();
            check("rand8", {ready8, sel8, sin8, gclr8, fs8, done8, busy8},
                  model_out(8, 1, k8, w8));
            check("rand4", {ready4, sel4, sin4, gclr4, fs4, done4, busy4},
                  model_out(4, 0, k4, w4));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mb_crc3_tx_ctrl.md
# mb_crc3_tx_ctrl

Frame-transmit controller that sequences the serial CRC-3 generator (polynomial x^3+x+1). It accepts a parallel data word over a valid/ready handshake, serialises it MSB-first into the generator with Select high, then drops Select for exactly 3 cycles so the generator appends its remainder. It then enforces an inter-frame gap and clears the generator between frames. It sits between the parallel host side and the serial link output.

## Interface
- DATA_W, 8, payload bits per frame (legal 2..32)
- GAP, 1, idle cycles forced after each frame's CRC (legal 0..15)
- GCLK  in  1  single clock; all state changes on rising edge
- CLEAR_bar  in  1  reset, synchronous, active-low
- Data_In  in  DATA_W  payload word, sampled on the accept edge
- Load  in  1  request to send Data_In
- Ready  out  1  high when a Load will be accepted this cycle
- Gen_Serial_In  out  1  drives the generator's Serial_In
- Select  out  1  drives the generator's Select: 1 = data phase, 0 = CRC phase or idle
- Gen_Clear_bar  out  1  drives the generator's clear, active-low
- Frame_Sync  out  1  one-cycle pulse coincident with the first data bit
- Done  out  1  one-cycle pulse coincident with the last CRC bit
- Busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, DATA, CRC, GAP. All outputs are registered (glitch-free into the generator clear).
- Reset (CLEAR_bar low at an edge) -> IDLE. Reset values: Ready=1, Select=0, Gen_Serial_In=0, Gen_Clear_bar=0, Frame_Sync=0, Done=0, Busy=0, shift register=0, counter=0.
- IDLE: Ready=1, Gen_Clear_bar=0 (generator held cleared), Select=0. On Load=1 at an edge:
  - capture Data_In into the shift register;
  - go to DATA with counter=DATA_W-1.
  - Load is ignored in every other state; Ready=0 there.
- DATA: Select=1, Gen_Clear_bar=1, Gen_Serial_In = shift-register MSB. The register shifts left one bit per cycle with zero fill.
  - counter decrements each cycle; at counter=0 go to CRC with counter=2.
- CRC: Select=0, Gen_Serial_In=0, Gen_Clear_bar=1. Counter decrements each cycle.
  - At counter=0: Done=1, then go to GAP (counter=GAP-1) if GAP>0, else to IDLE.
- GAP: all outputs as IDLE except Ready=0 and Busy=1. Gen_Clear_bar=0. At counter=0 go to IDLE.
- Counter width = clog2(max(DATA_W,GAP,3)). No arithmetic wrap is permitted; the counter is reloaded on every state entry.
- Reset mid-frame: immediate return to IDLE on that edge. The partial frame is abandoned and the generator is cleared by Gen_Clear_bar=0 from the next cycle. There is no Done pulse.
- Load held high continuously: a new frame starts at the first IDLE edge, giving back-to-back frames separated by GAP+1 idle cycles. This is the IDLE cycle during which Gen_Clear_bar=0, guaranteeing a zero remainder at frame start.

## Timing
- The accept edge is the rising edge with Load=1 and Ready=1; call it edge 0.
- Cycles 1..DATA_W: DATA phase, Select=1. Cycle 1 carries Data_In[DATA_W-1] with Frame_Sync=1; cycle DATA_W carries Data_In[0].
- Cycles DATA_W+1..DATA_W+3: CRC phase, Select=0. Done=1 in cycle DATA_W+3.
- Cycles DATA_W+4..DATA_W+3+GAP: GAP phase. Ready returns high in cycle DATA_W+4+GAP.
- Frame length on the link is DATA_W+3 cycles. Minimum accept-to-accept period is DATA_W+4+GAP cycles.
- Busy rises in cycle 1 and falls in the cycle Ready rises.

## Test plan
- Reset check: assert CLEAR_bar=0 for 2 cycles with Load=1. Required: Ready=1, Busy=0, Select=0, Gen_Clear_bar=0 throughout. No frame starts until the first edge with CLEAR_bar=1.
- Single frame with the generator attached, DATA_W=8, GAP=1, Data_In=8'h80.
  - Select is 1 for 8 cycles, then 0 for 3 cycles.
  - Link serial output reads 1,0,0,0,0,0,0,0,0,1,1 (CRC=3'b011).
  - Frame_Sync is high in cycle 1; Done is high in cycle 11; Ready returns in cycle 13.
- Back-to-back frames with Load held high, data 8'hA5 then 8'h3C, GAP=1.
  - Second Frame_Sync occurs exactly 13 cycles after the first.
  - Gen_Clear_bar is low for exactly 2 cycles between the frames.
  - Each CRC matches the software model.
- Load pulsed during DATA, CRC and GAP: each pulse is ignored, and the Done count stays 1 per accepted Load.
- Reset mid-frame: assert CLEAR_bar=0 in cycle 5 of the DATA phase.
  - Next cycle: state IDLE, Select=0, Gen_Clear_bar=0, no Done pulse.
  - A following frame with 8'h80 still yields CRC 3'b011.
- GAP=0 build with DATA_W=4 and Data_In=4'h1 at the accept edge: Done occurs in cycle 7, Ready=1 in cycle 8, and the next accept is possible at the end of cycle 8.
